// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequential load/store unit sitting between the MEM stage and an Avalon-MM
//   data bus. One request is accepted at a time. Each request becomes one bus
//   beat, or two beats when the datum crosses a bus-word boundary. Load data is
//   assembled low byte first and then formatted: sign/zero extension, or the
//   LWL/LWR merge with rt. All bus outputs are registered and held while
//   waitrequest is high.
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_op/addr/rt   request handshake and fields
//   o_rsp_valid/data/err  one-cycle completion pulse with load result / error
//   o_avm_*               Avalon master: address, read, write, byteenable, writedata
//   i_avm_readdata, i_avm_waitrequest   Avalon read data and stall
module mem_access_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [3:0]              i_req_op,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [31:0]             i_req_rt,
    output logic                    o_rsp_valid,
    output logic [31:0]             o_rsp_data,
    output logic                    o_rsp_err,
    output logic [ADDR_WIDTH-1:0]   o_avm_address,
    output logic                    o_avm_read,
    output logic                    o_avm_write,
    output logic [DATA_WIDTH/8-1:0] o_avm_byteenable,
    output logic [DATA_WIDTH-1:0]   o_avm_writedata,
    input  logic [DATA_WIDTH-1:0]   i_avm_readdata,
    input  logic                    i_avm_waitrequest
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2, S_RESP} state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd6) || (op >= 4'd8 && op <= 4'd10);
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd8: return 1;
            4'd2, 4'd3, 4'd9: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic op_lwlr(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6);
    endfunction

    // LWL/LWR always touch the whole 32-bit word holding the address,
    // so their lane offset is word aligned and they never cross.
    function automatic int op_off(input logic [3:0] op, input logic [OFFW-1:0] lo);
        int o;
        o = int'(lo);
        if (op_lwlr(op)) o = o & ~3;
        return o;
    endfunction

    // Datum byte index carried by lane k: beat 1 starts at lane off,
    // beat 2 continues from lane 0 with the bytes beat 1 could not hold.
    function automatic logic [LANES-1:0] beat_be(input int off, input int size, input logic second);
        logic [LANES-1:0] be;
        int idx;
        be = '0;
        for (int k = 0; k < LANES; k++) begin
            idx   = k - off + (second ? LANES : 0);
            be[k] = (idx >= 0) && (idx < size);
        end
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_wd(input int off, input int size,
                                                      input logic second, input logic [31:0] rt);
        logic [DATA_WIDTH-1:0] wd;
        int idx;
        wd = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = k - off + (second ? LANES : 0);
            if (idx >= 0 && idx < size) wd[8*k +: 8] = rt[8*idx +: 8];
        end
        return wd;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] ld, input logic [DATA_WIDTH-1:0] rd,
                                          input int off, input int size, input logic second);
        logic [31:0] m;
        int idx;
        m = ld;
        for (int k = 0; k < LANES; k++) begin
            idx = k - off + (second ? LANES : 0);
            if (idx >= 0 && idx < size) m[8*idx +: 8] = rd[8*k +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] fmt(input logic [3:0] op, input logic [1:0] b,
                                        input logic [31:0] w, input logic [31:0] rt);
        int          bi;
        logic [31:0] keep;
        bi = int'(b);
        case (op)
            4'd0: return {{24{w[7]}}, w[7:0]};
            4'd1: return {24'd0, w[7:0]};
            4'd2: return {{16{w[15]}}, w[15:0]};
            4'd3: return {16'd0, w[15:0]};
            4'd5: begin
                // word bytes b..0 land in the top of rt; low 3-b rt bytes survive
                keep = (32'h1 << (8 * (3 - bi))) - 32'h1;
                return (w << (8 * (3 - bi))) | (rt & keep);
            end
            4'd6: begin
                // word bytes 3..b land in the bottom of rt; top b rt bytes survive
                keep = ~(32'hFFFF_FFFF >> (8 * bi));
                return (w >> (8 * bi)) | (rt & keep);
            end
            default: return w;
        endcase
    endfunction

    state_t                  r_state;
    logic [3:0]              r_op;
    logic [OFFW-1:0]         r_addr_lo;
    logic [31:0]             r_rt;
    logic [31:0]             r_ld;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic [31:0]             r_rsp_data;
    logic [ADDR_WIDTH-1:0]   r_avm_address;
    logic                    r_avm_read;
    logic                    r_avm_write;
    logic [LANES-1:0]        r_avm_be;
    logic [DATA_WIDTH-1:0]   r_avm_wd;

    int          w_in_off, w_in_size, w_off, w_size;
    logic        w_in_err, w_cross;
    logic [31:0] w_ld_now, w_fmt;

    assign w_in_off  = op_off(i_req_op, i_req_addr[OFFW-1:0]);
    assign w_in_size = op_size(i_req_op);
    assign w_in_err  = !op_legal(i_req_op) ||
                       (!ALLOW_MISALIGNED && !op_lwlr(i_req_op) &&
                        ((int'(i_req_addr[1:0]) & (w_in_size - 1)) != 0));

    assign w_off    = op_off(r_op, r_addr_lo);
    assign w_size   = op_size(r_op);
    assign w_cross  = (w_off + w_size) > LANES;
    // Load bytes including whatever the beat completing this cycle returns.
    assign w_ld_now = merge(r_ld, i_avm_readdata, w_off, w_size, r_state == S_BEAT2);
    assign w_fmt    = r_op[3] ? 32'd0 : fmt(r_op, r_addr_lo[1:0], w_ld_now, r_rt);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_addr_lo     <= '0;
            r_rt          <= '0;
            r_ld          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_data    <= '0;
            r_avm_address <= '0;
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_avm_be      <= '0;
            r_avm_wd      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_op      <= i_req_op;
                    r_addr_lo <= i_req_addr[OFFW-1:0];
                    r_rt      <= i_req_rt;
                    r_ld      <= '0;
                    if (w_in_err) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end else begin
                        r_state       <= S_BEAT1;
                        r_avm_address <= {i_req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                        r_avm_read    <= !i_req_op[3];
                        r_avm_write   <= i_req_op[3];
                        r_avm_be      <= beat_be(w_in_off, w_in_size, 1'b0);
                        r_avm_wd      <= i_req_op[3] ? beat_wd(w_in_off, w_in_size, 1'b0, i_req_rt)
                                                     : '0;
                    end
                end
                S_BEAT1, S_BEAT2: if (!i_avm_waitrequest) begin
                    r_ld <= w_ld_now;
                    if (r_state == S_BEAT1 && w_cross) begin
                        r_state       <= S_BEAT2;
                        r_avm_address <= r_avm_address + ADDR_WIDTH'(LANES);
                        r_avm_be      <= beat_be(w_off, w_size, 1'b1);
                        r_avm_wd      <= r_op[3] ? beat_wd(w_off, w_size, 1'b1, r_rt) : '0;
                    end else begin
                        r_state     <= S_RESP;
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        r_avm_be    <= '0;
                        r_avm_wd    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_fmt;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_rsp_err  <= 1'b0;
                    r_rsp_data <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready      = (r_state == S_IDLE);
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_data       = r_rsp_data;
    assign o_rsp_err        = r_rsp_err;
    assign o_avm_address    = r_avm_address;
    assign o_avm_read       = r_avm_read;
    assign o_avm_write      = r_avm_write;
    assign o_avm_byteenable = r_avm_be;
    assign o_avm_writedata  = r_avm_wd;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two 32-bit instances, [1] with misaligned splitting,
// [0] reporting misalignment as an error. A byte-addressed reference model
// predicts bus beats and the load result for every request.
module tb_mem_access_unit;
    logic        clk, rst;
    logic        vld [2];
    logic        rdy [2], rv [2], rerr [2], ard [2], awr [2];
    logic [31:0] rdat [2], aaddr [2], awd [2];
    logic [3:0]  abe [2];
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_rt, rdata;
    logic        wreq;

    int n_checks = 0, n_errors = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] exp_addr [$], exp_wd [$];
    logic [3:0]  exp_be [$];

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(vld[1]), .o_req_ready(rdy[1]),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_rt(req_rt),
        .o_rsp_valid(rv[1]), .o_rsp_data(rdat[1]), .o_rsp_err(rerr[1]),
        .o_avm_address(aaddr[1]), .o_avm_read(ard[1]), .o_avm_write(awr[1]),
        .o_avm_byteenable(abe[1]), .o_avm_writedata(awd[1]),
        .i_avm_readdata(rdata), .i_avm_waitrequest(wreq));

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_req_valid(vld[0]), .o_req_ready(rdy[0]),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_rt(req_rt),
        .o_rsp_valid(rv[0]), .o_rsp_data(rdat[0]), .o_rsp_err(rerr[0]),
        .o_avm_address(aaddr[0]), .o_avm_read(ard[0]), .o_avm_write(awr[0]),
        .o_avm_byteenable(abe[0]), .o_avm_writedata(awd[0]),
        .i_avm_readdata(rdata), .i_avm_waitrequest(wreq));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a * 32'h9E37_79B1;
        return h[31:24];
    endfunction

    function automatic logic [31:0] line(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) mem[a + i] = v[8*i +: 8];
    endtask

    // Walk the datum byte by byte: each byte address falls in some bus word,
    // consecutive distinct words become consecutive beats.
    task automatic model(input bit allow, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, output bit err, output logic [31:0] rsp);
        int          size, b, n;
        bit          lwlr;
        logic [31:0] base, ba, w, t;
        exp_addr.delete(); exp_be.delete(); exp_wd.delete();
        size = (op == 0 || op == 1 || op == 8) ? 1 : (op == 2 || op == 3 || op == 9) ? 2 : 4;
        lwlr = (op == 5 || op == 6);
        base = lwlr ? {addr[31:2], 2'b00} : addr;
        err  = !(op inside {0, 1, 2, 3, 4, 5, 6, 8, 9, 10}) ||
               (!allow && !lwlr && (addr % size) != 0);
        rsp  = 0;
        if (err) return;
        w = 0;
        for (int j = 0; j < size; j++) begin
            ba = base + j;
            if (exp_addr.size() == 0 || exp_addr[exp_addr.size()-1] != {ba[31:2], 2'b00}) begin
                exp_addr.push_back({ba[31:2], 2'b00}); exp_be.push_back(0); exp_wd.push_back(0);
            end
            n = exp_addr.size() - 1;
            exp_be[n] = exp_be[n] | (4'b1 << ba[1:0]);
            if (op[3]) begin t = exp_wd[n]; t[8*ba[1:0] +: 8] = rt[8*j +: 8]; exp_wd[n] = t; end
            w[8*j +: 8] = mem_byte(ba);
        end
        b = int'(addr[1:0]);
        case (op)
            0: rsp = $signed(w[7:0]);
            1: rsp = {24'd0, w[7:0]};
            2: rsp = $signed(w[15:0]);
            3: rsp = {16'd0, w[15:0]};
            4: rsp = w;
            5: begin rsp = rt; for (int i = 0; i <= b; i++) rsp[8*(3-b+i) +: 8] = w[8*i +: 8]; end
            6: begin rsp = rt; for (int i = b; i < 4; i++) rsp[8*(i-b) +: 8] = w[8*i +: 8]; end
            default: rsp = 0;
        endcase
    endtask

    task automatic run_txn(input int s, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input int w1, input int w2,
                           input bit abort, output logic [31:0] got);
        bit          err;
        logic [31:0] rsp;
        int          w;
        model(s == 1, op, addr, rt, err, rsp);
        got = 0;
        req_op = op; req_addr = addr; req_rt = rt; vld[s] = 1'b1;
        chk("ready_idle", rdy[s], 1);
        @(posedge clk); #1;
        vld[s] = 1'b0;
        req_op = 4'($urandom); req_addr = $urandom; req_rt = $urandom;
        if (err) begin
            chk("err_ctl", {rv[s], rerr[s], ard[s], awr[s], rdy[s]}, 5'b11000);
            chk("err_data", rdat[s], 0);
            got = rdat[s];
        end else begin
            for (int b = 0; b < exp_addr.size(); b++) begin
                w = (b == 0) ? w1 : w2;
                if (abort && b == 1) begin
                    chk("abort_beat2", {ard[s], aaddr[s]}, {1'b1, exp_addr[1]});
                    rst = 1'b1; rdata = $urandom;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    chk("abort_ctl", {rv[s], ard[s], awr[s], rdy[s]}, 4'b0001);
                    @(posedge clk); #1;
                    chk("abort_quiet", {rv[s], ard[s], awr[s]}, 0);
                    return;
                end
                for (int i = 0; i <= w; i++) begin
                    chk("beat_ctl", {rv[s], ard[s], awr[s], abe[s]}, {1'b0, !op[3], op[3], exp_be[b]});
                    chk("beat_addr", aaddr[s], exp_addr[b]);
                    if (op[3]) chk("beat_wd", awd[s], exp_wd[b]);
                    wreq  = (i < w);
                    rdata = (i < w) ? $urandom : line(exp_addr[b]);
                    @(posedge clk); #1;
                end
            end
            wreq = 1'b0;
            chk("rsp_ctl", {rv[s], rerr[s], ard[s], awr[s], rdy[s]}, 5'b10000);
            chk("rsp_data", rdat[s], rsp);
            got = rdat[s];
        end
        @(posedge clk); #1;
        chk("post_rsp", {rv[s], rdy[s]}, 2'b01);
    endtask

    initial begin
        logic [31:0] got;
        logic [3:0]  ops [11];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd7};
        clk = 0; rst = 1; vld[0] = 0; vld[1] = 0; wreq = 0; rdata = 0;
        req_op = 0; req_addr = 0; req_rt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {rv[1], rerr[1], ard[1], awr[1], abe[1]}, 0);
        chk("rst_bus", {aaddr[1], awd[1]}, 0);
        chk("rst_data", rdat[1], 0);
        rst = 0;
        @(posedge clk); #1;
        chk("rst_ready", {rdy[1], rdy[0]}, 2'b11);

        set_word(32'h1000, 32'h8011_2233);
        run_txn(1, 4'd0, 32'h1003, 0, 0, 0, 0, got);   chk("lb_sext", got, 32'hFFFF_FF80);
        run_txn(1, 4'd1, 32'h1003, 0, 1, 0, 0, got);   chk("lbu_zext", got, 32'h0000_0080);
        run_txn(1, 4'd8, 32'h2002, 32'hAB, 0, 0, 0, got);
        set_word(32'h1000, 32'h4433_2211); set_word(32'h1004, 32'h8877_6655);
        run_txn(1, 4'd4, 32'h1002, 0, 0, 0, 0, got);   chk("lw_split", got, 32'h6655_4433);
        run_txn(1, 4'd10, 32'h3000, 32'hCAFE_F00D, 3, 0, 0, got);
        run_txn(0, 4'd2, 32'h1001, 0, 0, 0, 0, got);
        run_txn(0, 4'd7, 32'h1000, 0, 0, 0, 0, got);
        run_txn(1, 4'd7, 32'h1000, 0, 0, 0, 0, got);
        set_word(32'h1000, 32'hDDCC_BBAA);
        run_txn(1, 4'd5, 32'h1001, 32'h1122_3344, 0, 0, 0, got); chk("lwl", got, 32'hBBAA_3344);
        run_txn(1, 4'd6, 32'h1001, 32'h1122_3344, 0, 0, 0, got); chk("lwr", got, 32'h11DD_CCBB);
        run_txn(1, 4'd9, 32'h4003, 32'h0000_BEEF, 1, 2, 0, got);
        run_txn(1, 4'd4, 32'h1002, 0, 0, 0, 1, got);
        run_txn(1, 4'd0, 32'h1000, 0, 0, 0, 0, got);

        for (int n = 0; n < 250; n++)
            run_txn(1, ops[$urandom_range(0, 10)], $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), 0, got);
        for (int n = 0; n < 80; n++)
            run_txn(0, ops[$urandom_range(0, 10)], $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), 0, got);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
